// File: rtl/pipe_stage_reg_if.sv
// Handshake bundle for one pipeline stage: upstream beat in, downstream beat out.
// The stage itself takes the slave modport; the surrounding pipeline takes master.
interface pipe_stage_reg_if #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8
) ();
    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic [CTRL_W-1:0] in_ctrl;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_data;
    logic [CTRL_W-1:0] out_ctrl;

    modport slave (
        input  in_valid, in_data, in_ctrl, out_ready,
        output in_ready, out_valid, out_data, out_ctrl
    );

    modport master (
        output in_valid, in_data, in_ctrl, out_ready,
        input  in_ready, out_valid, out_data, out_ctrl
    );
endinterface

// File: rtl/pipe_stage_reg.sv
// Pipeline stage register built as a 2-entry skid buffer with a registered in_ready,
// flush that squashes control fields, and a saturating downstream-stall counter.
module pipe_stage_reg #(
    parameter int DATA_W = 96,
    parameter int CTRL_W = 8,
    parameter int CNT_W  = 16
) (
    input  logic             clk,
    input  logic             resetn,
    input  logic             flush,
    input  logic             clear_count,
    output logic [CNT_W-1:0] stall_count,
    pipe_stage_reg_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        FULL  = 2'd1,
        SKID  = 2'd2
    } state_e;

    state_e            state_q, state_d;
    logic [DATA_W-1:0] main_data_q, main_data_d;
    logic [CTRL_W-1:0] main_ctrl_q, main_ctrl_d;
    logic [DATA_W-1:0] skid_data_q, skid_data_d;
    logic [CTRL_W-1:0] skid_ctrl_q, skid_ctrl_d;
    logic              in_ready_q, in_ready_d;
    logic [CNT_W-1:0]  stall_q, stall_d;

    logic out_valid;
    logic accept;
    logic deliver;

    assign out_valid = (state_q != EMPTY);
    assign accept    = bus.in_valid & in_ready_q;
    assign deliver   = out_valid & bus.out_ready;

    always_comb begin
        // NOTE: every signal gets a default before any branch, so no path leaves it unassigned (no latch).
        state_d     = state_q;
        main_data_d = main_data_q;
        main_ctrl_d = main_ctrl_q;
        skid_data_d = skid_data_q;
        skid_ctrl_d = skid_ctrl_q;

        unique case (state_q)
            EMPTY: begin
                if (accept) begin
                    main_data_d = bus.in_data;
                    main_ctrl_d = bus.in_ctrl;
                    state_d     = FULL;
                end
            end
            FULL: begin
                if (accept && deliver) begin
                    main_data_d = bus.in_data;
                    main_ctrl_d = bus.in_ctrl;
                end else if (accept) begin
                    skid_data_d = bus.in_data;
                    skid_ctrl_d = bus.in_ctrl;
                    state_d     = SKID;
                end else if (deliver) begin
                    state_d = EMPTY;
                end
            end
            SKID: begin
                if (deliver) begin
                    main_data_d = skid_data_q;
                    main_ctrl_d = skid_ctrl_q;
                    state_d     = FULL;
                end
            end
            default: state_d = EMPTY;
        endcase

        // Flush squashes control (turning held beats into bubbles) but leaves payload alone,
        // which also discards any beat accepted this cycle.
        if (flush) begin
            state_d     = EMPTY;
            main_data_d = main_data_q;
            skid_data_d = skid_data_q;
            main_ctrl_d = '0;
            skid_ctrl_d = '0;
        end
    end

    // in_ready is a flop computed from the next state, so out_ready never reaches it combinationally.
    assign in_ready_d = (state_d != SKID);

    always_comb begin
        stall_d = stall_q;
        if (clear_count) begin
            stall_d = '0;
        end else if (out_valid && !bus.out_ready && (stall_q != {CNT_W{1'b1}})) begin
            stall_d = stall_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        // NOTE: non-blocking assignments so every flop samples pre-edge values regardless of statement order.
        if (!resetn) begin
            state_q     <= EMPTY;
            in_ready_q  <= 1'b1;
            stall_q     <= '0;
            // NOTE: payload registers are reset too, so out_data reads zero after reset instead of stale data.
            main_data_q <= '0;
            main_ctrl_q <= '0;
            skid_data_q <= '0;
            skid_ctrl_q <= '0;
        end else begin
            state_q     <= state_d;
            in_ready_q  <= in_ready_d;
            stall_q     <= stall_d;
            main_data_q <= main_data_d;
            main_ctrl_q <= main_ctrl_d;
            skid_data_q <= skid_data_d;
            skid_ctrl_q <= skid_ctrl_d;
        end
    end

    assign bus.in_ready  = in_ready_q;
    assign bus.out_valid = out_valid;
    assign bus.out_data  = main_data_q;
    assign bus.out_ctrl  = out_valid ? main_ctrl_q : '0;
    assign stall_count   = stall_q;

endmodule

// File: doc/pipe_stage_reg.md
PIPE_STAGE_REG -- requirements
Module: pipe_stage_reg

Interface
REQ-001 SHALL have parameter DATA_W, default 96, meaning the datapath payload width (operands, store data, rd address).
REQ-002 SHALL have parameter CTRL_W, default 8, meaning the control field width (reg_write, mem_write, ALU op, writeback select); this field is zeroed in bubbles.
REQ-003 SHALL have parameter CNT_W, default 16, meaning the stall counter width.
REQ-004 SHALL have port clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-005 SHALL have port resetn, input, 1 bit: reset, synchronous, active-low.
REQ-006 SHALL have port in_valid, input, 1 bit: upstream beat present.
REQ-007 SHALL have port in_ready, output, 1 bit: stage can accept; driven directly from a register.
REQ-008 SHALL have port in_data, input, DATA_W bits: upstream payload.
REQ-009 SHALL have port in_ctrl, input, CTRL_W bits: upstream control field.
REQ-010 SHALL have port flush, input, 1 bit: kill all held beats (branch or exception).
REQ-011 SHALL have port out_valid, output, 1 bit: downstream beat present.
REQ-012 SHALL have port out_ready, input, 1 bit: downstream accepts.
REQ-013 SHALL have port out_data, output, DATA_W bits: held payload.
REQ-014 SHALL have port out_ctrl, output, CTRL_W bits: held control field; all zero when out_valid=0.
REQ-015 SHALL have port clear_count, input, 1 bit: synchronous clear of stall_count.
REQ-016 SHALL have port stall_count, output, CNT_W bits: saturating count of downstream stall cycles.

Function
REQ-017 SHALL treat a beat as accepted when in_valid=1 and in_ready=1, and as delivered when out_valid=1 and out_ready=1.
REQ-018 SHALL implement a 2-entry skid buffer with states EMPTY, FULL and SKID: main register only (FULL), or main register plus skid register (SKID).
REQ-019 SHALL drive in_ready=1 in EMPTY and FULL and in_ready=0 in SKID, with no combinational path from out_ready to in_ready.
REQ-020 SHALL drive out_valid=1 in FULL and SKID, and out_data/out_ctrl from the main register.
REQ-021 SHALL, in EMPTY, load an accepted beat into main and go to FULL; with no accept, it SHALL stay in EMPTY.
REQ-022 SHALL, in FULL, handle each accept/deliver combination as follows: accept only -> capture into skid, go to SKID; deliver only -> go to EMPTY; both -> load main with the new beat, stay FULL; neither -> hold.
REQ-023 SHALL, in SKID, on deliver, move skid into main and go to FULL; with no deliver, it SHALL hold all contents.
REQ-024 SHALL add 1 cycle of latency from accept to out_valid when empty, and SHALL sustain 1 beat per cycle when out_ready=1.
REQ-025 SHALL preserve beat order, and SHALL neither drop nor duplicate beats except on flush.
REQ-026 SHALL, when flush=1, take priority over all other events: next state EMPTY, main and skid ctrl fields zeroed, data fields unchanged.
REQ-027 SHALL discard a beat accepted in the same cycle as flush, and SHALL count no delivery in that cycle for stall purposes.
REQ-028 SHALL increment stall_count by 1 on every cycle with out_valid=1 and out_ready=0, saturating at 2^CNT_W-1 (no wrap).
REQ-029 SHALL, when clear_count=1, set stall_count to 0 next cycle; clear SHALL win over a simultaneous increment.

Reset
REQ-030 SHALL, on resetn=0 at a clock edge, set state EMPTY, in_ready=1, out_valid=0, out_data=0, out_ctrl=0, skid contents=0 and stall_count=0.
REQ-031 SHALL give reset priority over flush, clear_count and all handshakes; a reset mid-transfer SHALL discard every held beat.

Verification
REQ-032 SHALL be verified by a streaming scenario: out_ready=1, beats D0..D7 on consecutive cycles -> out_data D0..D7 one cycle later, no gaps, in_ready stays 1, stall_count=0.
REQ-033 SHALL be verified by a backpressure scenario: out_ready=0 with beats A, B presented -> FULL after A, SKID after B, in_ready=0; out_ready=1 for two cycles -> A then B delivered, in_ready=1.
REQ-034 SHALL be verified by a flush scenario: SKID holding A, B, flush=1 with C presented -> next cycle out_valid=0, out_ctrl=0, in_ready=1; A, B and C are never delivered.
REQ-035 SHALL be verified by a saturation scenario: CNT_W=4, out_valid=1 with out_ready=0 for 20 cycles -> stall_count=15 and holds; clear_count=1 together with a stall -> 0.
REQ-036 SHALL be verified by a reset scenario: resetn=0 while in SKID -> next cycle all outputs per REQ-030; the first beat after reset is delivered with 1-cycle latency.
REQ-037 SHALL be verified by a random scenario: random in_valid/out_ready over 10k cycles, no flush -> delivered sequence equals accepted sequence, and in_ready=0 only in SKID.
